// File: rtl/gbf_fill_scheduler_pkg.sv
// Shared definitions for the global-buffer fill scheduler: buffer ids,
// FSM encoding and the fill-length clamp.
package gbf_fill_scheduler_pkg;

  localparam int DFLT_DATA_BITWIDTH = 256;
  localparam int DFLT_ADDR_BITWIDTH = 5;
  localparam int DFLT_DEPTH         = 32;

  localparam logic [1:0] ID_ACTV1 = 2'd0;
  localparam logic [1:0] ID_ACTV2 = 2'd1;
  localparam logic [1:0] ID_WGT1  = 2'd2;
  localparam logic [1:0] ID_WGT2  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } fill_state_t;

  // A zero or oversize request means "fill the whole buffer".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return ((len == 32'd0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/gbf_fill_scheduler_arb.sv
// Four-way round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] id
);

  logic [1:0] idx;

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    grant = 4'b0000;
    id    = 2'd0;
    idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx   = ptr + 2'(k);
      grant = req[idx] ? (4'b0001 << idx) : grant;
      id    = req[idx] ? idx : id;
    end
  end

endmodule

// File: rtl/gbf_fill_scheduler.sv
// Arbitrates buffer refill requests onto one fill stream and drives the
// shared port-A write bus of the granted ping-pong buffer.
module gbf_fill_scheduler
  import gbf_fill_scheduler_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = DFLT_DATA_BITWIDTH,
  parameter int GBF_ADDR_BITWIDTH = DFLT_ADDR_BITWIDTH,
  parameter int GBF_DEPTH         = DFLT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   need_data,
  input  logic                         finish,
  input  logic [GBF_ADDR_BITWIDTH:0]   cfg_actv_len,
  input  logic [GBF_ADDR_BITWIDTH:0]   cfg_wgt_len,
  output logic                         src_req,
  output logic [1:0]                   src_id,
  output logic [GBF_ADDR_BITWIDTH:0]   src_len,
  input  logic                         src_ack,
  input  logic                         src_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] src_data,
  output logic                         src_ready,
  output logic [3:0]                   gbf_en,
  output logic [3:0]                   gbf_we,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_addr,
  output logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data,
  output logic [3:0]                   buf_ready,
  output logic                         actv_data_avail,
  output logic                         wgt_data_avail
);

  localparam int LEN_W = GBF_ADDR_BITWIDTH + 1;

  fill_state_t      state;
  fill_state_t      state_next;
  logic [1:0]       ptr;
  logic [3:0]       served;
  logic [LEN_W-1:0] beat_cnt;
  logic [3:0]       eligible;
  logic [3:0]       arb_grant;
  logic [1:0]       arb_id;
  logic             arb_valid;
  logic [LEN_W-1:0] len_sel;
  logic [LEN_W-1:0] len_clamped;
  logic [3:0]       fill_onehot;
  logic             beat_accept;
  logic             last_beat;

  assign eligible    = need_data & ~served & {4{~finish}};
  assign arb_valid   = |arb_grant;
  assign len_sel     = (arb_id >= ID_WGT1) ? cfg_wgt_len : cfg_actv_len;
  assign len_clamped = LEN_W'(clamp_len(32'(len_sel), GBF_DEPTH));
  assign fill_onehot = 4'b0001 << src_id;
  assign beat_accept = src_valid & src_ready;
  assign last_beat   = beat_accept & (beat_cnt == (src_len - LEN_W'(1)));

  rr_arbiter4 u_arb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (arb_grant),
    .id    (arb_id)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = arb_valid ? ST_REQ : ST_IDLE;
      ST_REQ:  state_next = src_ack ? ST_XFER : ST_REQ;
      ST_XFER: state_next = last_beat ? ST_DONE : ST_XFER;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request handshake, beat counting, write bus and completion bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr             <= 2'd0;
      served          <= 4'b0000;
      beat_cnt        <= '0;
      src_req         <= 1'b0;
      src_id          <= 2'd0;
      src_len         <= '0;
      src_ready       <= 1'b0;
      gbf_en          <= 4'b0000;
      gbf_we          <= 4'b0000;
      gbf_addr        <= '0;
      gbf_w_data      <= '0;
      buf_ready       <= 4'b0000;
      actv_data_avail <= 1'b0;
      wgt_data_avail  <= 1'b0;
    end else begin
      gbf_en    <= 4'b0000;
      gbf_we    <= 4'b0000;
      buf_ready <= 4'b0000;
      served    <= served & need_data;
      if (finish) begin
        actv_data_avail <= 1'b0;
        wgt_data_avail  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            src_req  <= 1'b1;
            src_id   <= arb_id;
            src_len  <= len_clamped;
            ptr      <= arb_id + 2'd1;
            beat_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (src_ack) begin
            src_req   <= 1'b0;
            src_ready <= 1'b1;
          end
        end
        ST_XFER: begin
          if (beat_accept) begin
            gbf_en     <= fill_onehot;
            gbf_we     <= fill_onehot;
            gbf_addr   <= beat_cnt[GBF_ADDR_BITWIDTH-1:0];
            gbf_w_data <= src_data;
            beat_cnt   <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              src_ready <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          // Completion wins over a concurrent finish so the flag reflects this fill.
          buf_ready <= fill_onehot;
          served    <= (served & need_data) | fill_onehot;
          if (src_id < ID_WGT1) begin
            actv_data_avail <= 1'b1;
          end else begin
            wgt_data_avail <= 1'b1;
          end
        end
        default: begin
          src_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gbf_fill_scheduler.sv
// Scoreboard bench for gbf_fill_scheduler: a random loader answers requests,
// expected writes/ready pulses are queued and checked by a separate monitor.
module tb_gbf_fill_scheduler;

  localparam int DW = 256;
  localparam int AW = 5;
  localparam int LW = 6;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    need_data = 4'b0000;
  logic          finish = 1'b0;
  logic [LW-1:0] cfg_actv_len = '0;
  logic [LW-1:0] cfg_wgt_len = '0;
  logic          src_req;
  logic [1:0]    src_id;
  logic [LW-1:0] src_len;
  logic          src_ack = 1'b0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic [3:0]    gbf_en;
  logic [3:0]    gbf_we;
  logic [AW-1:0] gbf_addr;
  logic [DW-1:0] gbf_w_data;
  logic [3:0]    buf_ready;
  logic          actv_data_avail;
  logic          wgt_data_avail;

  gbf_fill_scheduler dut (
    .clk(clk), .reset(reset), .need_data(need_data), .finish(finish),
    .cfg_actv_len(cfg_actv_len), .cfg_wgt_len(cfg_wgt_len),
    .src_req(src_req), .src_id(src_id), .src_len(src_len), .src_ack(src_ack),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .gbf_en(gbf_en), .gbf_we(gbf_we), .gbf_addr(gbf_addr), .gbf_w_data(gbf_w_data),
    .buf_ready(buf_ready), .actv_data_avail(actv_data_avail), .wgt_data_avail(wgt_data_avail)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] id; logic [LW-1:0] len; } req_t;
  typedef struct { logic [1:0] id; logic [AW-1:0] addr; logic [DW-1:0] data; int unsigned cyc; } wr_t;
  typedef struct { logic [1:0] id; int unsigned cyc; } rdy_t;

  req_t exp_req[$];
  wr_t  exp_wr[$];
  rdy_t exp_rdy[$];

  int unsigned nvec = 0;
  int unsigned nfail = 0;
  int unsigned cyc = 0;

  int unsigned   model_ptr = 0;
  logic [3:0]    model_served = 4'b0000;
  logic          model_a = 1'b0;
  logic          model_w = 1'b0;

  int            ld_state = 0;
  int            ld_wait = 0;
  int unsigned   ld_cnt = 0;
  logic [1:0]    ld_id = 2'd0;
  logic [LW-1:0] ld_len = '0;
  req_t          ld_r;
  wr_t           ld_w;
  rdy_t          ld_rd;
  wr_t           mon_w;
  rdy_t          mon_r;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] exp_len(input int unsigned id);
    int unsigned l;
    l = (id < 2) ? int'(cfg_actv_len) : int'(cfg_wgt_len);
    if (l == 0 || l > DEPTH) l = DEPTH;
    return LW'(l);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Loader model: acks after a random delay, then offers beats with random gaps.
  always @(negedge clk) begin
    if (reset) begin
      ld_state = 0;
      ld_cnt = 0;
      src_ack = 1'b0;
      src_valid = 1'b0;
      exp_wr.delete();
      exp_rdy.delete();
    end else begin
      case (ld_state)
        0: begin
          src_valid = 1'b0;
          src_ack = 1'b0;
          ld_cnt = 0;
          if (src_req) begin
            if (exp_req.size() == 0) begin
              nvec++;
              nfail++;
              $display("FAIL unexpected_grant: id %0d len %0d, no grant expected", src_id, src_len);
              ld_id = src_id;
              ld_len = src_len;
            end else begin
              ld_r = exp_req.pop_front();
              chk("grant_id", 256'(src_id), 256'(ld_r.id));
              chk("grant_len", 256'(src_len), 256'(ld_r.len));
              ld_id = ld_r.id;
              ld_len = ld_r.len;
            end
            ld_wait = $urandom_range(0, 3);
            ld_state = 1;
          end
        end
        1: begin
          if (ld_wait == 0) begin
            src_ack = 1'b1;
            ld_state = 2;
          end else begin
            ld_wait--;
          end
        end
        2: begin
          src_ack = 1'b0;
          src_valid = ($urandom_range(0, 2) != 0);
          for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = $urandom;
          if (src_valid && src_ready) begin
            ld_w.id = ld_id;
            ld_w.addr = ld_cnt[AW-1:0];
            ld_w.data = src_data;
            ld_w.cyc = cyc + 1;
            exp_wr.push_back(ld_w);
            ld_cnt++;
            if (ld_cnt == ld_len) begin
              ld_rd.id = ld_id;
              ld_rd.cyc = cyc + 2;
              exp_rdy.push_back(ld_rd);
              ld_state = 0;
            end
          end
        end
        default: ld_state = 0;
      endcase
    end
  end

  // Monitor: every write and ready pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (gbf_we != 4'b0000 || gbf_en != 4'b0000) begin
        if (exp_wr.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL stray_write: en %b we %b addr %0d, no write expected", gbf_en, gbf_we, gbf_addr);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_en", 256'(gbf_en), 256'(4'b0001 << mon_w.id));
          chk("wr_we", 256'(gbf_we), 256'(4'b0001 << mon_w.id));
          chk("wr_addr", 256'(gbf_addr), 256'(mon_w.addr));
          chk("wr_data", gbf_w_data, mon_w.data);
          chk("wr_cycle", 256'(cyc), 256'(mon_w.cyc));
        end
      end else if (exp_wr.size() != 0 && exp_wr[0].cyc < cyc) begin
        nvec++;
        nfail++;
        $display("FAIL missing_write: addr %0d due cycle %0d, absent at cycle %0d", exp_wr[0].addr, exp_wr[0].cyc, cyc);
        mon_w = exp_wr.pop_front();
      end
      if (buf_ready != 4'b0000) begin
        if (exp_rdy.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL stray_ready: buf_ready %b, no pulse expected", buf_ready);
        end else begin
          mon_r = exp_rdy.pop_front();
          chk("ready_id", 256'(buf_ready), 256'(4'b0001 << mon_r.id));
          chk("ready_cycle", 256'(cyc), 256'(mon_r.cyc));
        end
      end else if (exp_rdy.size() != 0 && exp_rdy[0].cyc < cyc) begin
        nvec++;
        nfail++;
        $display("FAIL missing_ready: id %0d due cycle %0d, absent at cycle %0d", exp_rdy[0].id, exp_rdy[0].cyc, cyc);
        mon_r = exp_rdy.pop_front();
      end
    end
  end

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(exp_req.size() == 0 && ld_state == 0 && exp_rdy.size() == 0 && exp_wr.size() == 0) && n < 4000);
    nvec++;
    if (n >= 4000) begin
      nfail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic wait_beats(input int unsigned target);
    int unsigned n;
    n = 0;
    while (!(ld_state == 2 && ld_cnt >= target) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    nvec++;
    if (n >= 2000) begin
      nfail++;
      $display("FAIL beat_wait_timeout: %0d beats seen, required %0d", ld_cnt, target);
    end
  endtask

  // Grants go cyclically from the pointer through every eligible requester.
  task automatic run_batch(input logic [3:0] need);
    req_t r;
    int unsigned id;
    for (int k = 0; k < 4; k++) begin
      id = (model_ptr + k) % 4;
      if (need[id] && !model_served[id]) begin
        r.id = 2'(id);
        r.len = exp_len(id);
        exp_req.push_back(r);
        model_served[id] = 1'b1;
        if (id < 2) model_a = 1'b1;
        else model_w = 1'b1;
      end
    end
    for (int k = 3; k >= 0; k--) begin
      id = (model_ptr + k) % 4;
      if (exp_req.size() != 0 && exp_req[exp_req.size()-1].id == 2'(id)) begin
        model_ptr = (id + 1) % 4;
        break;
      end
    end
    need_data = need;
    wait_idle("batch");
    chk("actv_avail", 256'(actv_data_avail), 256'(model_a));
    chk("wgt_avail", 256'(wgt_data_avail), 256'(model_w));
  endtask

  task automatic drop_need();
    need_data = 4'b0000;
    model_served = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    req_t r;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 256'({src_req, src_id, src_len, src_ready, gbf_en, gbf_we, gbf_addr,
                            buf_ready, actv_data_avail, wgt_data_avail}), 256'(0));
    chk("reset_wdata", gbf_w_data, 256'(0));
    #1 reset = 1'b0;

    cfg_actv_len = 6'd4;
    cfg_wgt_len = 6'd2;
    run_batch(4'b0001);
    drop_need();

    cfg_actv_len = 6'd2;
    cfg_wgt_len = 6'd2;
    run_batch(4'b1111);
    repeat (20) @(negedge clk);
    #1;
    need_data = 4'b1110;
    model_served[0] = 1'b0;
    @(negedge clk);
    #1;
    run_batch(4'b1111);
    drop_need();

    cfg_wgt_len = 6'd0;
    run_batch(4'b0100);
    drop_need();
    cfg_wgt_len = 6'd40;
    run_batch(4'b0100);
    drop_need();

    for (int n = 0; n < 6; n++) begin
      cfg_actv_len = LW'($urandom_range(0, 63));
      cfg_wgt_len = LW'($urandom_range(0, 63));
      run_batch(4'($urandom_range(1, 15)));
      drop_need();
    end

    cfg_actv_len = 6'd8;
    r.id = 2'd0;
    r.len = 6'd8;
    exp_req.push_back(r);
    need_data = 4'b0001;
    wait_beats(3);
    #1 reset = 1'b1;
    #1;
    chk("midreset_ctrl", 256'({src_req, src_id, src_len, src_ready, gbf_en, gbf_we, gbf_addr,
                               buf_ready, actv_data_avail, wgt_data_avail}), 256'(0));
    chk("midreset_wdata", gbf_w_data, 256'(0));
    need_data = 4'b0000;
    exp_req.delete();
    model_ptr = 0;
    model_served = 4'b0000;
    model_a = 1'b0;
    model_w = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    cfg_actv_len = 6'd4;
    run_batch(4'b0001);
    drop_need();

    cfg_actv_len = 6'd8;
    cfg_wgt_len = 6'd8;
    for (int k = 0; k < 4; k++) begin
      if (exp_req.size() == 0 && ((4'b1110 >> ((model_ptr + k) % 4)) & 4'b0001) != 4'b0000) begin
        r.id = 2'((model_ptr + k) % 4);
        r.len = 6'd8;
        exp_req.push_back(r);
      end
    end
    model_ptr = (int'(r.id) + 1) % 4;
    need_data = 4'b1110;
    wait_beats(2);
    finish = 1'b1;
    wait_idle("finish_xfer");
    repeat (20) @(negedge clk);
    #1;
    chk("finish_actv_avail", 256'(actv_data_avail), 256'(0));
    chk("finish_wgt_avail", 256'(wgt_data_avail), 256'(0));
    need_data = 4'b0000;
    repeat (2) @(negedge clk);
    finish = 1'b0;
    model_served = 4'b0000;
    model_a = 1'b0;
    model_w = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    chk("queues_drained", 256'(exp_req.size() + exp_wr.size() + exp_rdy.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gbf_fill_scheduler.md
Name: gbf_fill_scheduler

Overview:
- Sequences refills of the four ping-pong global buffers: actv buf1/2 and wgt buf1/2.
- Arbitrates the buffers' need_data requests onto a single external 256-bit fill stream.
- Drives the port-A write signals of the granted buffer and returns per-buffer ready pulses and data_avail flags to the gbf controller.
- Sits between the off-chip loader/DMA and the accelerator datapath top; the top fans the shared write bus out to all four buffers.

Parameters:
- GBF_DATA_BITWIDTH, 256, width of one buffer line and of the stream beat.
- GBF_ADDR_BITWIDTH, 5, actv/wgt buffer address width.
- GBF_DEPTH, 32, lines per buffer.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- need_data  in  4  level requests; bit0 actv_gbf1, bit1 actv_gbf2, bit2 wgt_gbf1, bit3 wgt_gbf2.
- finish  in  1  layer done; blocks new grants, clears data_avail flags.
- cfg_actv_len  in  GBF_ADDR_BITWIDTH+1  lines per actv fill.
- cfg_wgt_len  in  GBF_ADDR_BITWIDTH+1  lines per wgt fill.
- src_req  out  1  fill request to loader.
- src_id  out  2  buffer id of the current request.
- src_len  out  GBF_ADDR_BITWIDTH+1  line count of the current request.
- src_ack  in  1  loader accepts the request.
- src_valid  in  1  stream beat valid.
- src_data  in  GBF_DATA_BITWIDTH  stream beat.
- src_ready  out  1  beat accepted when src_valid & src_ready.
- gbf_en  out  4  per-buffer port-A enable (same bit order as need_data).
- gbf_we  out  4  per-buffer port-A write enable.
- gbf_addr  out  GBF_ADDR_BITWIDTH  shared write address.
- gbf_w_data  out  GBF_DATA_BITWIDTH  shared write data.
- buf_ready  out  4  one-cycle pulse per buffer: fill complete.
- actv_data_avail  out  1  at least one actv fill done since reset/finish.
- wgt_data_avail  out  1  at least one wgt fill done since reset/finish.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; served mask 0; beat counter 0.
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE
  - Eligible set = need_data & ~served & {4{~finish}}.
  - Grant the first eligible id at or after the pointer (cyclic 0..3). Latch id and len; set pointer = id+1 mod 4; go to REQ next cycle.
  - len = cfg_actv_len for ids 0-1, cfg_wgt_len for ids 2-3. A value of 0 or >GBF_DEPTH is clamped to GBF_DEPTH.
- REQ
  - src_req=1, with src_id/src_len held stable until src_ack.
  - On src_ack: src_req drops next cycle; go to XFER.
- XFER
  - src_ready=1 while beat_cnt < len.
  - Each accepted beat registers, for the next cycle: gbf_en[id]=gbf_we[id]=1, gbf_addr=beat_cnt, gbf_w_data=src_data. Then beat_cnt++.
  - One-cycle write latency; no writes in any other cycle.
  - Acceptance of beat len-1 moves to DONE.
  - src_valid low stalls without penalty.
- DONE (1 cycle)
  - The last write is visible this cycle.
  - Next cycle: buf_ready[id] pulses, served[id] is set, the matching data_avail flag is set, and state returns to IDLE.
- served[i] clears in any cycle where need_data[i]==0. A buffer is re-granted only after its need_data has been seen low.
- finish
  - Clears both data_avail flags.
  - Suppresses new grants while high.
  - A transfer already in REQ/XFER/DONE completes normally, including its ready pulse and flag set.
- A need_data drop mid-transfer does not abort the transfer.
- beat_cnt width is GBF_ADDR_BITWIDTH+1, so len=GBF_DEPTH writes addr 0..GBF_DEPTH-1 with no wrap.
- Only one grant at a time; simultaneous requests are resolved purely by the pointer.
- Reset mid-operation: all state returns to reset values immediately; any partial fill is discarded and no ready pulse is issued.

Decomposition:
- Shared package holds:
  - buffer id constants: ID_ACTV1=0, ID_ACTV2=1, ID_WGT1=2, ID_WGT2=3;
  - FSM state encoding;
  - the len-clamp function.
- One sub-module: rr_arbiter4 (request vector and pointer in, one-hot grant and encoded id out, purely combinational); all sequencing stays in the top.

Test Plan:
- need_data=0001, cfg_actv_len=4, src_ack after 2 cycles, src_valid continuous -> gbf_we[0] on 4 consecutive cycles with addr 0,1,2,3 and data matching the beats; buf_ready[0] pulses 2 cycles after the last accepted beat; actv_data_avail=1.
- need_data=1111, all lens 2, always acked -> grant order ids 0,1,2,3; a request raised again for id 0 without first dropping is ignored until need_data[0] goes low then high.
- cfg_wgt_len=0 with need_data=0100 -> 32 writes, addr 0..31, single buf_ready[2]; cfg_wgt_len=40 gives the same result.
- src_valid toggling 1,0,0,1 during XFER -> writes occur only the cycle after each accepted beat, addresses stay contiguous, and the total write count equals len.
- finish=1 during XFER of id 1 with need_data=1110 -> transfer completes and buf_ready[1] pulses; no new grant while finish stays high; both data_avail flags read 0 after finish.
- reset asserted at beat 3 of 8 -> all outputs 0 in the same cycle; after release, the next grant starts at id 0 with addr 0 and no stale buf_ready pulse.
